// File: rtl/alu_exec_unit.sv
// Registered ALU execution stage: single-cycle add/complement/and/xor/diff, iterative 1-bit-per-cycle shifter.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic             select,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [4:0]       shcnt;
  logic [WIDTH:0]   sum;
  logic [5:0]       diff_idx;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             go_shift;

  assign shcnt = select ? shamt : op_b[4:0];
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_comb begin
    sum      = {1'b0, op_a} + {1'b0, op_b};
    diff_idx = 6'd32;
    for (int i = WIDTH-1; i >= 0; i--)
      if (op_a[i] != op_b[i]) diff_idx = 6'(i);
    alu_res   = '0;
    alu_carry = 1'b0;
    case (control)
      3'b000: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'b001: begin
        alu_res   = (~op_b) + WIDTH'(1);
        alu_carry = (op_b == '0);
      end
      3'b010: alu_res = op_a & op_b;
      3'b011: alu_res = op_a ^ op_b;
      3'b100: alu_res = {{(WIDTH-6){1'b0}}, diff_idx};
`ifdef ALU_BARREL_SHIFT_EN
      // Extra guard bit on the far side of the shift catches the last bit shifted out.
      3'b101:  {alu_carry, alu_res} = {1'b0, op_a} << shcnt;
      3'b110:  {alu_res, alu_carry} = {op_a, 1'b0} >> shcnt;
      default: {alu_res, alu_carry} = $signed({op_a, 1'b0}) >>> shcnt;
`else
      // Only reached for shifts with a zero count; nonzero counts go through SHIFT.
      default: alu_res = op_a;
`endif
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;
`else
  logic [WIDTH-1:0] work;
  logic [4:0]       cnt;
  logic [1:0]       sh_op;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;

  assign go_shift = control[2] && (control[1:0] != 2'b00) && (shcnt != 5'd0);

  always_comb begin
    case (sh_op)
      2'b10: begin
        sh_nxt = {1'b0, work[WIDTH-1:1]};
        sh_out = work[0];
      end
      2'b11: begin
        sh_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
        sh_out = work[0];
      end
      default: begin
        sh_nxt = {work[WIDTH-2:0], 1'b0};
        sh_out = work[WIDTH-1];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      cnt   <= '0;
      sh_op <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        work  <= op_a;
        cnt   <= shcnt;
        sh_op <= control[1:0];
      end
    end else if (state == SHIFT) begin
      work <= sh_nxt;
      cnt  <= cnt - 5'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      sign   <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            if (go_shift) begin
              state <= SHIFT;
            end else begin
              result <= alu_res;
              carry  <= alu_carry;
              zero   <= (alu_res == '0);
              sign   <= alu_res[WIDTH-1];
              state  <= DONE;
            end
          end
`ifdef ALU_BARREL_SHIFT_EN
        SHIFT: state <= IDLE;
`else
        SHIFT:
          if (cnt == 5'd1) begin
            result <= sh_nxt;
            carry  <= sh_out;
            zero   <= (sh_nxt == '0);
            sign   <= sh_nxt[WIDTH-1];
            state  <= DONE;
          end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit against an arithmetic reference model, plus directed corner cases.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  control = '0;
  logic        select = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, carry, zero, sign;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prev_res = '0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .control(control), .select(select),
    .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {carry, result} computed directly from the operation definitions.
  function automatic logic [32:0] ref_model(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input int n);
    logic [63:0] w;
    logic [31:0] x;
    logic [31:0] r;
    logic        cy;
    r  = '0;
    cy = 1'b0;
    case (c)
      3'd0: begin w = 64'(a) + 64'(b); r = w[31:0]; cy = w[32]; end
      3'd1: begin r = 32'd0 - b; cy = (b == 32'd0); end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: begin
        x = a ^ b;
        r = (x == 32'd0) ? 32'd32 : 32'($clog2(x & (~x + 32'd1)));
      end
      3'd5: begin w = 64'(a) << n; r = w[31:0]; cy = w[32]; end
      3'd6: begin r = a >> n; cy = (n == 0) ? 1'b0 : a[n-1]; end
      default: begin r = 32'($signed(a) >>> n); cy = (n == 0) ? 1'b0 : a[n-1]; end
    endcase
    return {cy, r};
  endfunction

  task automatic accept(input logic [2:0] c, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    control = c; select = s; op_a = a; op_b = b; shamt = sh; start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    control = 3'($urandom);
    select  = 1'($urandom);
    op_a    = $urandom;
    op_b    = $urandom;
    shamt   = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] c, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input bit poke);
    logic [32:0] e;
    int n, lat;
    n = s ? int'(sh) : int'(b[4:0]);
    e = ref_model(c, a, b, n);
`ifdef ALU_BARREL_SHIFT_EN
    lat = 1;
`else
    lat = (c >= 3'd5 && n != 0) ? n + 1 : 1;
`endif
    accept(c, s, a, b, sh);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k <= lat) begin
        chk("busy", 64'(busy), 64'd1);
        chk("done", 64'(done), 64'(k == lat));
        if (k < lat) chk("hold", 64'(result), 64'(prev_res));
        else begin
          chk("result", 64'(result), 64'(e[31:0]));
          chk("carry",  64'(carry),  64'(e[32]));
          chk("zero",   64'(zero),   64'(e[31:0] == 32'd0));
          chk("sign",   64'(sign),   64'(e[31]));
        end
      end else begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
      end
      // Stray start requests during cycles 2 and 3 of a long op must be dropped.
      start = poke && (k == 1 || k == 2);
    end
    start    = 1'b0;
    prev_res = e[31:0];
  endtask

  initial begin
    logic [2:0]  c;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", {61'd0, carry, zero, sign}, 64'd0);
    rst = 1'b0;

    run_op(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    run_op(3'b001, 1'b0, 32'h1234_5678, 32'd5, 5'd0, 1'b0);
    run_op(3'b001, 1'b0, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
    run_op(3'b100, 1'b0, 32'h10, 32'h30, 5'd0, 1'b0);
    run_op(3'b100, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd0, 1'b0);
    run_op(3'b111, 1'b1, 32'h8000_0000, 32'h0, 5'd4, 1'b0);
    run_op(3'b110, 1'b0, 32'h3, 32'h21, 5'd7, 1'b0);
    run_op(3'b110, 1'b0, 32'h3, 32'h20, 5'd7, 1'b0);
    run_op(3'b101, 1'b1, 32'h8000_0001, 32'h0, 5'd31, 1'b0);
    run_op(3'b101, 1'b0, 32'h00FF_00FF, 32'h8, 5'd0, 1'b1);

    // Abort an sll with N=10 in cycle 3; reset also wins over a concurrent start.
    accept(3'b101, 1'b1, 32'h1234_5678, 32'h0, 5'd10);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd1);
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_low", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", {61'd0, carry, zero, sign}, 64'd0);
    prev_res = '0;
    run_op(3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = 32'd0;
        2: a = 32'h8000_0000 | a;
        default: ;
      endcase
      run_op(c, 1'($urandom), a, b, 5'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
